// File: rtl/if_bus_if.sv
// Instruction-fetch bus interface: zero-latency fetch from the scratch-pad memory,
// otherwise a request/grant/ready read on the system bus, with a hold buffer for stalls.
module if_bus_if #(
  parameter logic [2:0]  SPM_SEL  = 3'b011,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [29:0] i_addr,
  input  logic        i_as,
  output logic [31:0] o_insn,
  output logic        o_busy,
  output logic [29:0] o_spm_addr,
  output logic        o_spm_as,
  input  logic [31:0] i_spm_rd_data,
  output logic        o_bus_req,
  input  logic        i_bus_grant,
  output logic [29:0] o_bus_addr,
  output logic        o_bus_as,
  input  logic [31:0] i_bus_rd_data,
  input  logic        i_bus_rdy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_bus_req;
  logic        r_bus_as;
  logic [29:0] r_bus_addr;
  logic [29:0] r_addr;
  logic [31:0] r_rd_buf;
  logic        w_start;
  logic        w_grant_take;
  logic        w_done;

  assign o_spm_addr = i_addr;
  assign o_bus_req  = r_bus_req;
  assign o_bus_as   = r_bus_as;
  assign o_bus_addr = r_bus_addr;

  // Next-state decode and combinational fetch outputs
  always_comb begin
    w_state_nxt  = r_state;
    o_insn       = NOP_INSN;
    o_busy       = 1'b0;
    o_spm_as     = 1'b0;
    w_start      = 1'b0;
    w_grant_take = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_flush) begin
          w_state_nxt = IDLE;
        end else if (i_as && (i_addr[29:27] == SPM_SEL)) begin
          o_spm_as = 1'b1;
          o_insn   = i_spm_rd_data;
        end else if (i_as) begin
          o_busy      = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        o_busy = 1'b1;
        if (i_bus_grant) begin
          w_grant_take = 1'b1;
          w_state_nxt  = ACCESS;
        end else begin
          w_state_nxt = REQ;
        end
      end
      ACCESS: begin
        // Flush is deliberately ignored here so an issued bus read always completes
        if (i_bus_rdy) begin
          o_insn      = i_bus_rd_data;
          w_done      = 1'b1;
          w_state_nxt = i_stall ? STALL : IDLE;
        end else begin
          o_busy = 1'b1;
        end
      end
      STALL: begin
        o_insn = r_rd_buf;
        if (i_stall) begin
          w_state_nxt = STALL;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, bus handshake registers and read buffer
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_bus_req  <= 1'b0;
      r_bus_as   <= 1'b0;
      r_bus_addr <= 30'd0;
      r_addr     <= 30'd0;
      r_rd_buf   <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_bus_as <= w_grant_take;
      if (w_start) begin
        r_addr    <= i_addr;
        r_bus_req <= 1'b1;
      end else if (w_done) begin
        r_bus_req <= 1'b0;
      end
      if (w_grant_take) begin
        r_bus_addr <= r_addr;
      end
      if (w_done) begin
        r_rd_buf <= i_bus_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_if_bus_if.sv
// Directed bench for if_bus_if: SPM fetch, bus fetch, stall hold, delayed grant,
// flush behaviour and reset in the middle of a bus transaction.
module tb_if_bus_if;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] addr;
  logic        as_s;
  logic [31:0] insn;
  logic        busy;
  logic [29:0] spm_addr;
  logic        spm_as;
  logic [31:0] spm_rd_data;
  logic        bus_req;
  logic        bus_grant;
  logic [29:0] bus_addr;
  logic        bus_as;
  logic [31:0] bus_rd_data;
  logic        bus_rdy;

  int vec_cnt = 0;
  int err_cnt = 0;

  if_bus_if dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_addr        (addr),
    .i_as          (as_s),
    .o_insn        (insn),
    .o_busy        (busy),
    .o_spm_addr    (spm_addr),
    .o_spm_as      (spm_as),
    .i_spm_rd_data (spm_rd_data),
    .o_bus_req     (bus_req),
    .i_bus_grant   (bus_grant),
    .o_bus_addr    (bus_addr),
    .o_bus_as      (bus_as),
    .i_bus_rd_data (bus_rd_data),
    .i_bus_rdy     (bus_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs are then changed and
  // outputs checked #1 later, well away from either clock edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = 30'd0; as_s = 1'b0;
    spm_rd_data = 32'd0; bus_grant = 1'b0; bus_rd_data = 32'd0; bus_rdy = 1'b0;
    #2;
    chk("rst_insn", insn, 32'h0000_0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_as", {31'd0, bus_as}, 32'd0);
    chk("rst_bus_addr", {2'd0, bus_addr}, 32'd0);
    cyc();
    reset = 1'b0;

    // SPM fetch
    cyc();
    addr = 30'h1800_0004; as_s = 1'b1; spm_rd_data = 32'hDEAD_BEEF; #1;
    chk("spm_insn", insn, 32'hDEAD_BEEF);
    chk("spm_busy", {31'd0, busy}, 32'd0);
    chk("spm_as", {31'd0, spm_as}, 32'd1);
    chk("spm_addr", {2'd0, spm_addr}, 32'h1800_0004);
    chk("spm_bus_req", {31'd0, bus_req}, 32'd0);
    cyc();
    as_s = 1'b0; #1;
    chk("spm_after_req", {31'd0, bus_req}, 32'd0);
    chk("idle_insn", insn, 32'h0000_0000);

    // stray grant/rdy in IDLE are ignored
    bus_grant = 1'b1; bus_rdy = 1'b1; bus_rd_data = 32'h5555_AAAA; #1;
    chk("stray_insn", insn, 32'h0000_0000);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    cyc();
    bus_grant = 1'b0; bus_rdy = 1'b0; #1;
    chk("stray_req", {31'd0, bus_req}, 32'd0);
    chk("stray_as", {31'd0, bus_as}, 32'd0);

    // bus fetch, grant one cycle after req, rdy the next cycle
    addr = 30'h0000_0010; as_s = 1'b1; #1;
    chk("bf_busy0", {31'd0, busy}, 32'd1);
    chk("bf_spm_as", {31'd0, spm_as}, 32'd0);
    cyc();
    bus_grant = 1'b1; #1;
    chk("bf_busy1", {31'd0, busy}, 32'd1);
    chk("bf_req1", {31'd0, bus_req}, 32'd1);
    chk("bf_as1", {31'd0, bus_as}, 32'd0);
    cyc();
    bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h1234_5678; as_s = 1'b0; #1;
    chk("bf_as2", {31'd0, bus_as}, 32'd1);
    chk("bf_addr2", {2'd0, bus_addr}, 32'h0000_0010);
    chk("bf_insn2", insn, 32'h1234_5678);
    chk("bf_busy2", {31'd0, busy}, 32'd0);
    chk("bf_spm_as2", {31'd0, spm_as}, 32'd0);
    cyc();
    bus_rdy = 1'b0; bus_rd_data = 32'hFFFF_0000; #1;
    chk("bf_as3", {31'd0, bus_as}, 32'd0);
    chk("bf_req3", {31'd0, bus_req}, 32'd0);
    chk("bf_insn3", insn, 32'h0000_0000);

    // stall hold: stall=1 at rdy, held 3 cycles
    addr = 30'h0000_0010; as_s = 1'b1; #1;
    cyc();
    bus_grant = 1'b1; #1;
    cyc();
    bus_grant = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h1234_5678; as_s = 1'b0; stall = 1'b1; #1;
    chk("st_insn0", insn, 32'h1234_5678);
    for (int i = 1; i < 3; i++) begin
      cyc();
      bus_rdy = 1'b0; bus_rd_data = 32'h0BAD_0BAD; #1;
      chk("st_insn_hold", insn, 32'h1234_5678);
      chk("st_busy_hold", {31'd0, busy}, 32'd0);
      chk("st_spm_as", {31'd0, spm_as}, 32'd0);
    end
    cyc();
    stall = 1'b0; #1;
    chk("st_insn_drop", insn, 32'h1234_5678);
    cyc();
    chk("st_idle_insn", insn, 32'h0000_0000);

    // delayed grant: 5 cycles without grant
    addr = 30'h0000_0040; as_s = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("dg_busy", {31'd0, busy}, 32'd1);
      chk("dg_req", {31'd0, bus_req}, 32'd1);
      chk("dg_as", {31'd0, bus_as}, 32'd0);
    end
    bus_grant = 1'b1; #1;
    cyc();
    bus_grant = 1'b0; #1;
    chk("dg_as_acc", {31'd0, bus_as}, 32'd1);
    chk("dg_addr", {2'd0, bus_addr}, 32'h0000_0040);
    chk("dg_busy_acc", {31'd0, busy}, 32'd1);
    cyc();
    chk("dg_as_once", {31'd0, bus_as}, 32'd0);
    chk("dg_busy_wait", {31'd0, busy}, 32'd1);
    bus_rdy = 1'b1; bus_rd_data = 32'hAAAA_5555; as_s = 1'b0; #1;
    chk("dg_insn", insn, 32'hAAAA_5555);
    chk("dg_busy_done", {31'd0, busy}, 32'd0);
    cyc();
    bus_rdy = 1'b0; #1;

    // flush in IDLE with as=1, bus and SPM addresses
    flush = 1'b1; as_s = 1'b1; addr = 30'h0000_0080; #1;
    chk("fl_insn", insn, 32'h0000_0000);
    chk("fl_busy", {31'd0, busy}, 32'd0);
    cyc();
    chk("fl_req", {31'd0, bus_req}, 32'd0);
    addr = 30'h1800_0008; spm_rd_data = 32'h0101_0101; #1;
    chk("fl_spm_as", {31'd0, spm_as}, 32'd0);
    chk("fl_spm_insn", insn, 32'h0000_0000);

    // flush during ACCESS does not abort
    flush = 1'b0; addr = 30'h0000_0100; #1;
    cyc();
    bus_grant = 1'b1; #1;
    cyc();
    bus_grant = 1'b0; flush = 1'b1; as_s = 1'b0; #1;
    chk("fla_busy", {31'd0, busy}, 32'd1);
    cyc();
    bus_rdy = 1'b1; bus_rd_data = 32'hCAFE_F00D; #1;
    chk("fla_insn", insn, 32'hCAFE_F00D);
    chk("fla_busy_done", {31'd0, busy}, 32'd0);
    cyc();
    bus_rdy = 1'b0; flush = 1'b0; #1;
    chk("fla_req_clr", {31'd0, bus_req}, 32'd0);

    // reset while in ACCESS
    addr = 30'h0000_0200; as_s = 1'b1; #1;
    cyc();
    bus_grant = 1'b1; #1;
    cyc();
    bus_grant = 1'b0; as_s = 1'b0; #1;
    chk("ra_as_pre", {31'd0, bus_as}, 32'd1);
    reset = 1'b1; #1;
    chk("ra_req", {31'd0, bus_req}, 32'd0);
    chk("ra_as", {31'd0, bus_as}, 32'd0);
    chk("ra_busy", {31'd0, busy}, 32'd0);
    chk("ra_insn", insn, 32'h0000_0000);
    cyc();
    reset = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h7777_7777; #1;
    chk("ra_rdy_ignored", insn, 32'h0000_0000);
    bus_rdy = 1'b0; addr = 30'h0000_0300; as_s = 1'b1; #1;
    chk("ra_new_busy", {31'd0, busy}, 32'd1);
    cyc();
    chk("ra_new_req", {31'd0, bus_req}, 32'd1);
    chk("ra_new_as", {31'd0, bus_as}, 32'd0);
    bus_grant = 1'b1; #1;
    cyc();
    bus_grant = 1'b0; as_s = 1'b0; bus_rdy = 1'b1; bus_rd_data = 32'h0300_0300; #1;
    chk("ra_new_addr", {2'd0, bus_addr}, 32'h0000_0300);
    chk("ra_new_insn", insn, 32'h0300_0300);
    cyc();
    bus_rdy = 1'b0; #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
